// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N burst requesters.
// Define FIFO_ARB_HIPRI_EN to make requester 0 win every IDLE arbitration.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int B         = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_last,
    input  logic [N*B-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [B-1:0]         fifo_w_data,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr, rr_nx, gid_nx, winner, gid_inc;
    logic [CW-1:0]  beat_cnt, cnt_nx;
    logic [IDW:0]   idx;
    logic           found, acc, burst_end;
    logic [B-1:0]   cur_data;

    assign cur_data    = req_data[grant_id*B +: B];
    assign grant_valid = (state == BUSY);
    // Explicit wrap so non-power-of-2 N never lands on an unused index.
    assign gid_inc     = (grant_id == IDW'(N-1)) ? '0 : grant_id + 1'b1;
    assign burst_end   = req_last[grant_id] || (beat_cnt == CW'(MAX_BURST-1));

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
`ifdef FIFO_ARB_HIPRI_EN
        if (req_valid[0]) winner = '0;
`endif
    end

    always_comb begin
        state_nx    = state;
        rr_nx       = rr_ptr;
        gid_nx      = grant_id;
        cnt_nx      = beat_cnt;
        req_ready   = '0;
        acc         = 1'b0;
        fifo_wr     = 1'b0;
        fifo_w_data = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nx = BUSY;
                    gid_nx   = winner;
                    cnt_nx   = '0;
                end
            end
            BUSY: begin
                req_ready[grant_id] = ~fifo_full;
                acc                 = req_valid[grant_id] & ~fifo_full;
                fifo_wr             = acc;
                if (acc) begin
                    fifo_w_data = cur_data;
                    cnt_nx      = beat_cnt + 1'b1;
                    if (burst_end) begin
                        state_nx = IDLE;
                        rr_nx    = gid_inc;
                        cnt_nx   = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_nx;
            grant_id <= gid_nx;
            beat_cnt <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester queues feed beats, a forked
// monitor checks every FIFO write against hand-computed data, requester and cycle.
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int B = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [N*B-1:0] req_data;
    logic           fifo_full, fifo_wr, grant_valid;
    logic [B-1:0]   fifo_w_data;
    logic [1:0]     grant_id;

    fifo_wr_arbiter #(.N(N), .B(B), .MAX_BURST(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data), .grant_valid(grant_valid),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         id;
        int         cy;
    } exp_t;

    exp_t       expq[$];
    logic [8:0] rq[N][$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [N-1:0] hs = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic drive_bus();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            h = '0;
            if (rq[i].size() > 0) h = rq[i][0];
            req_valid[i]         = (rq[i].size() > 0);
            req_last[i]          = h[8];
            req_data[i*B +: B]   = h[7:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        drive_bus();
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
        drive_bus();
    endtask

    task automatic expect_w(input logic [7:0] d, input int id, input int off);
        expq.push_back('{d, id, cyc + off});
    endtask

    function automatic int pending();
        int p = expq.size();
        for (int i = 0; i < N; i++) p += rq[i].size();
        return p;
    endfunction

    task automatic drain(input int lim);
        int n = 0;
        while (pending() > 0 && n < lim) begin
            tick();
            n++;
        end
        chk("drain_pending", pending(), 0);
        expq.delete();
        for (int i = 0; i < N; i++) rq[i].delete();
        drive_bus();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            hs = reset ? '0 : (req_valid & req_ready);
            if (grant_valid === 1'b1)
                chk("one_hot_ready", 32'($countones(req_ready) <= 1), 1);
            if (fifo_wr === 1'b1) begin
                chk("no_wr_when_full", fifo_full, 0);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h expected=none (cycle %0d)", fifo_w_data, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("wr_data", fifo_w_data, e.d);
                    chk("wr_id", grant_id, e.id);
                    chk("wr_cycle", cyc, e.cy);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        reset = 1'b1; fifo_full = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        drive_bus();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_w_data", fifo_w_data, 0);
        tick();
        reset = 1'b0;

        // single requester, 3-beat burst
        tick();
        push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
        expect_w(8'hA1, 0, 1); expect_w(8'hA2, 0, 2); expect_w(8'hA3, 0, 3);
        @(negedge clk);
        chk("arb_latency_idle", grant_valid, 0);
        @(negedge clk);
        chk("grant_valid_t1", grant_valid, 1);
        chk("grant_id_t1", grant_id, 0);
        drain(40);
        @(negedge clk);
        chk("idle_bubble", grant_valid, 0);
        chk("idle_w_data", fifo_w_data, 0);

        // all requesters, 1-beat bursts; rr_ptr is 1 after the previous burst
        tick();
        for (int i = 0; i < N; i++)
            for (int n = 0; n < 2; n++) push(i, 8'(16*(i+1) + n), 1);
        for (int k = 0; k < 8; k++)
            expect_w(8'(16*(((1+k)%4)+1) + k/4), (1+k)%4, 1 + 2*k);
        drain(60);

        // forced release at MAX_BURST, then requester 3 served before 2 again
        tick();
        for (int n = 0; n < 20; n++) push(2, 8'(8'h60 + n), n == 19);
        push(3, 8'hC3, 1);
        for (int n = 0; n < 16; n++) expect_w(8'(8'h60 + n), 2, 1 + n);
        expect_w(8'hC3, 3, 18);
        for (int n = 16; n < 20; n++) expect_w(8'(8'h60 + n), 2, 20 + (n - 16));
        drain(80);

        // reset mid-burst after beat 2 of 4
        tick();
        for (int n = 0; n < 4; n++) push(2, 8'(8'h90 + n), n == 3);
        expect_w(8'h90, 2, 1); expect_w(8'h91, 2, 2);
        tick(); tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_grant_valid", grant_valid, 0);
        chk("midrst_fifo_wr", fifo_wr, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_exp_drained", expq.size(), 0);
        for (int i = 0; i < N; i++) rq[i].delete();
        drive_bus();
        tick();
        reset = 1'b0;
        push(1, 8'hE1, 1); push(3, 8'hE3, 1);
        expect_w(8'hE1, 1, 1); expect_w(8'hE3, 3, 3);
        drain(40);
        tick();
        push(2, 8'hE2, 1);
        expect_w(8'hE2, 2, 1);
        drain(40);

        // backpressure for 5 cycles mid-burst
        tick();
        for (int n = 0; n < 6; n++) push(3, 8'(8'h80 + n), n == 5);
        expect_w(8'h80, 3, 1); expect_w(8'h81, 3, 2);
        for (int n = 2; n < 6; n++) expect_w(8'(8'h80 + n), 3, 6 + n);
        tick(); tick(); tick();
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_fifo_wr", fifo_wr, 0);
            chk("stall_grant_held", grant_valid, 1);
            tick();
        end
        fifo_full = 1'b0;
        drain(40);

        // priority check with rr_ptr=1 and req_valid=1011
        tick();
        push(0, 8'hF8, 1);
        expect_w(8'hF8, 0, 1);
        drain(20);
        tick();
        push(0, 8'hF0, 1); push(1, 8'hF1, 1); push(3, 8'hF3, 1);
`ifdef FIFO_ARB_HIPRI_EN
        expect_w(8'hF0, 0, 1); expect_w(8'hF1, 1, 3); expect_w(8'hF3, 3, 5);
`else
        expect_w(8'hF1, 1, 1); expect_w(8'hF3, 3, 3); expect_w(8'hF0, 0, 5);
`endif
        drain(40);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
